// File: rtl/key_device_pkg.sv
// key_device_pkg: register offsets and KCTRL bit positions shared by the key device files
package key_device_pkg;
    localparam logic [31:0] KDATA_OFS = 32'd0;
    localparam logic [31:0] KCTRL_OFS = 32'd4;
    localparam int READY = 0;
    localparam int OVR   = 1;
    localparam int IE    = 8;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, hold counter and accepted level for one push-button
module key_debounce #(
    parameter int DEBOUNCE = 50000,
    parameter int CNTBITS  = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic IN,
    output logic OUT,
    output logic ROSE
);
    logic [1:0]         r_sync;
    logic [CNTBITS-1:0] r_cnt;
    logic               r_stable;
    logic               w_diff;
    logic               w_done;
    assign w_diff = r_sync[1] ^ r_stable;
    assign w_done = w_diff && (r_cnt == CNTBITS'(DEBOUNCE - 1));
    assign OUT    = r_stable;
    assign ROSE   = w_done && r_sync[1];
    // Bring the asynchronous button into the clock domain
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) r_sync <= '0;
        else       r_sync <= {r_sync[0], IN};
    // Accept a new level only once it has held for DEBOUNCE consecutive cycles
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_cnt    <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
            r_stable <= w_done ? r_sync[1] : r_stable;
        end
endmodule

// File: rtl/key_device.sv
// key_device: memory-mapped debounced push-button port with sticky Ready/Overrun and optional IRQ (KEY_IRQ_EN)
module key_device
    import key_device_pkg::*;
#(
    parameter int              BITS     = 32,
    parameter int              KEYBITS  = 4,
    parameter logic [BITS-1:0] BASE     = 32'hFFFF0100,
    parameter int              DEBOUNCE = 50000,
    parameter int              CNTBITS  = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [BITS-1:0]    ADDRBUS,
    inout  wire  [BITS-1:0]    DATABUS,
    input  logic               WE,
    input  logic [KEYBITS-1:0] KEY,
    output logic               IRQ
);
    logic [KEYBITS-1:0] w_stable;
    logic [KEYBITS-1:0] w_rose;
    logic               w_hit_data;
    logic               w_hit_ctrl;
    logic               w_rd_data;
    logic               w_wr_ctrl;
    logic               w_press;
    logic               w_clr_ready;
    logic               w_ie;
    logic [BITS-1:0]    w_ctrl;
    logic [BITS-1:0]    w_rdata;
    logic               r_ready;
    logic               r_ovr;

    for (genvar i = 0; i < KEYBITS; i++) begin : g_key
        key_debounce #(.DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)) u_db (
            .CLK  (CLK),
            .RESET(RESET),
            .IN   (KEY[i]),
            .OUT  (w_stable[i]),
            .ROSE (w_rose[i])
        );
    end

    assign w_hit_data  = ADDRBUS == BITS'(BASE + KDATA_OFS);
    assign w_hit_ctrl  = ADDRBUS == BITS'(BASE + KCTRL_OFS);
    assign w_rd_data   = w_hit_data && !WE;
    assign w_wr_ctrl   = w_hit_ctrl && WE;
    assign w_press     = |w_rose;
    assign w_clr_ready = w_rd_data || (w_wr_ctrl && !DATABUS[READY]);

    // Press events set Ready and win over any same-edge clear; Overrun flags a press Ready would not absorb
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ready <= w_press || (r_ready && !w_clr_ready);
            r_ovr   <= (w_press && r_ready && !w_clr_ready) || (r_ovr && !(w_wr_ctrl && !DATABUS[OVR]));
        end

`ifdef KEY_IRQ_EN
    logic r_ie;
    // IE tracks bit 8 of every KCTRL write
    always_ff @(posedge CLK or posedge RESET)
        if (RESET)          r_ie <= 1'b0;
        else if (w_wr_ctrl) r_ie <= DATABUS[IE];
    assign w_ie = r_ie;
`else
    assign w_ie = 1'b0;
`endif

    // Assemble the KCTRL read word
    always_comb begin
        w_ctrl        = '0;
        w_ctrl[READY] = r_ready;
        w_ctrl[OVR]   = r_ovr;
        w_ctrl[IE]    = w_ie;
    end

    assign w_rdata = w_hit_data ? BITS'(w_stable) : w_ctrl;
    assign DATABUS = (!WE && (w_hit_data || w_hit_ctrl)) ? w_rdata : 'z;
    assign IRQ     = w_ie && r_ready;
endmodule

// File: tb/tb_key_device.sv
// tb_key_device: randomized and directed checks of key_device against a sample-history model
module tb_key_device;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'hFFFF0100;
    localparam logic [31:0] KD   = BASE;
    localparam logic [31:0] KC   = BASE + 32'd4;
    localparam logic [31:0] K8   = BASE + 32'd8;
    localparam logic [31:0] IDLE = 32'h0000_0000;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;
`ifdef KEY_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] addr  = IDLE;
    logic [31:0] wdata = '0;
    logic [3:0]  key   = '0;
    logic        irq;
    wire  [31:0] databus;

    assign databus = we ? wdata : 'z;
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup (databus[g]);
    end

    key_device #(.BITS(32), .KEYBITS(4), .BASE(BASE), .DEBOUNCE(D), .CNTBITS(16)) dut (
        .CLK    (clk),
        .RESET  (rst),
        .ADDRBUS(addr),
        .DATABUS(databus),
        .WE     (we),
        .KEY    (key),
        .IRQ    (irq)
    );

    always #10 clk = ~clk;

    int pass_n  = 0;
    int total_n = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    // Model: hist[k] is KEY as sampled k edges ago; a key adopts a level once the
    // synchronised samples (2 edges old) have shown that same new level D times running.
    logic [3:0] hist [0:D+1];
    logic [3:0] m_stable;
    logic       m_ready, m_ovr, m_ie;

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] ns;
        logic       press, rd_d, wr_c, clr, same;
        if (rst) begin
            for (int k = 0; k <= D + 1; k++) hist[k] = '0;
            m_stable = '0;
            m_ready  = 1'b0;
            m_ovr    = 1'b0;
            m_ie     = 1'b0;
        end else begin
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = key;
            ns = m_stable;
            for (int i = 0; i < 4; i++) begin
                same = 1'b1;
                for (int k = 3; k <= D + 1; k++) if (hist[k][i] != hist[2][i]) same = 1'b0;
                if (same && hist[2][i] != m_stable[i]) ns[i] = hist[2][i];
            end
            press = |(ns & ~m_stable);
            rd_d  = !we && addr == KD;
            wr_c  = we && addr == KC;
            clr   = rd_d || (wr_c && !wdata[0]);
            if (press && m_ready && !clr) m_ovr = 1'b1;
            else if (wr_c && !wdata[1])   m_ovr = 1'b0;
            if (press)    m_ready = 1'b1;
            else if (clr) m_ready = 1'b0;
            if (wr_c && IRQ_EN) m_ie = wdata[8];
            m_stable = ns;
        end
    end

    function automatic logic [31:0] exp_bus();
        if (we)         return wdata;
        if (addr == KD) return {28'b0, m_stable};
        if (addr == KC) return {23'b0, m_ie, 6'b0, m_ovr, m_ready};
        return NONE;
    endfunction

    // Every cycle, compare the bus and IRQ against the model
    always begin
        @(negedge clk);
        #1;
        chk("irq", {31'b0, irq}, {31'b0, m_ie & m_ready});
        chk("bus", databus, exp_bus());
    end

    task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        #3;
        addr = a;
        we   = 1'b0;
        #1;
        d    = databus;
        addr = IDLE;
        chk(nm, d, exp);
    endtask

    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        we    = w;
        wdata = d;
        @(negedge clk);
        addr  = IDLE;
        we    = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_n(3);
        rst = 1'b0;
        peek("rst_kdata", KD, 32'h0);
        peek("rst_kctrl", KC, 32'h0);
        peek("rst_unmapped", K8, NONE);
        // Press qualifies exactly 2+D edges after the raw change
        @(negedge clk);
        key = 4'b0010;
        for (int c = 1; c <= 8; c++) peek("latency", KD, c >= 6 ? 32'h2 : 32'h0);
        peek("press_ready", KC, 32'h1);
        // A 3-cycle pulse is rejected
        @(negedge clk);
        key = 4'b0011;
        wait_n(3);
        key = 4'b0010;
        wait_n(10);
        peek("glitch_kdata", KD, 32'h2);
        peek("glitch_kctrl", KC, 32'h1);
        // Read-to-clear, release ignored, overrun
        cyc(KD, 1'b0, 32'h0);
        peek("rtc", KC, 32'h0);
        key = 4'b0000;
        wait_n(10);
        peek("release_kctrl", KC, 32'h0);
        peek("release_kdata", KD, 32'h0);
        key = 4'b0001;
        wait_n(10);
        peek("press2", KC, 32'h1);
        key = 4'b0011;
        wait_n(10);
        peek("overrun", KC, 32'h3);
        cyc(KC, 1'b1, 32'h0);
        peek("wr_clear", KC, 32'h0);
        // Press on the same edge as a KDATA read
        @(negedge clk);
        key = 4'b0111;
        wait_n(5);
        addr = KD;
        we   = 1'b0;
        @(negedge clk);
        addr = IDLE;
        peek("same_edge_kctrl", KC, 32'h1);
        peek("same_edge_kdata", KD, 32'h7);
        cyc(KC, 1'b1, 32'h0);
        // Interrupt enable
        key = 4'b0000;
        wait_n(10);
        cyc(KC, 1'b1, 32'h100);
        @(negedge clk);
        key = 4'b1000;
        wait_n(10);
        peek("ie_kctrl", KC, IRQ_EN ? 32'h101 : 32'h1);
        chk("ie_irq", {31'b0, irq}, {31'b0, IRQ_EN});
        cyc(KC, 1'b1, 32'h100);
        chk("ie_clear_irq", {31'b0, irq}, 32'h0);
        peek("ie_clear_kctrl", KC, IRQ_EN ? 32'h100 : 32'h0);
        key = 4'b0000;
        wait_n(10);
        key = 4'b0001;
        wait_n(10);
        // Unmapped and read-only accesses
        cyc(KD, 1'b1, NONE);
        peek("kdata_wr_ignored", KC, IRQ_EN ? 32'h101 : 32'h1);
        peek("kdata_unchanged", KD, 32'h1);
        cyc(K8, 1'b1, 32'h0);
        cyc(K8, 1'b0, 32'h0);
        peek("base8_nodrive", K8, NONE);
        peek("base8_no_effect", KC, IRQ_EN ? 32'h101 : 32'h1);
        // Asynchronous reset mid-run while the key stays held
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_irq", {31'b0, irq}, 32'h0);
        peek("async_kdata", KD, 32'h0);
        peek("async_kctrl", KC, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) peek("requalify", KC, c >= 6 ? 32'h1 : 32'h0);
        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) key = 4'($urandom);
            addr  = IDLE;
            we    = 1'b0;
            wdata = $urandom;
            case ($urandom_range(0, 7))
                0: addr = KD;
                1: addr = KC;
                2: begin addr = KC; we = 1'b1; end
                3: begin addr = KD; we = 1'b1; end
                4: begin addr = K8; we = 1'($urandom); end
                default: addr = IDLE;
            endcase
        end
        @(negedge clk);
        addr = IDLE;
        we   = 1'b0;
        wait_n(2);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
